// File: rtl/regbank_mp_if.sv
// Bundle of read, write-back and scoreboard signals between the core pipeline
// (master) and the multi-port register bank (slave).
interface regbank_mp_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int RD_PORTS = 2
);
  // No valid/ready here. Every input is sampled on each rising clk edge.
  // wa_we/wb_we/pend_set qualify their address/data for that edge only.
  // Read results appear one edge later.
  logic [RD_PORTS*ADDR_W-1:0] rd_addr;
  logic [RD_PORTS*DATA_W-1:0] rd_data;
  logic [RD_PORTS-1:0]        rd_pending;
  logic                       hold;
  logic                       clear;
  logic                       wa_we;
  logic [ADDR_W-1:0]          wa_addr;
  logic [DATA_W-1:0]          wa_data;
  logic                       wb_we;
  logic [ADDR_W-1:0]          wb_addr;
  logic [DATA_W-1:0]          wb_data;
  logic                       pend_set;
  logic [ADDR_W-1:0]          pend_addr;
  logic                       pend_any;

  modport master (
    output rd_addr, hold, clear, wa_we, wa_addr, wa_data,
           wb_we, wb_addr, wb_data, pend_set, pend_addr,
    input  rd_data, rd_pending, pend_any
  );

  modport slave (
    input  rd_addr, hold, clear, wa_we, wa_addr, wa_data,
           wb_we, wb_addr, wb_data, pend_set, pend_addr,
    output rd_data, rd_pending, pend_any
  );
endinterface

// File: rtl/regbank_mp.sv
// Multi-port register bank: N registered read ports with write-through bypass,
// two write-back ports (A wins on collision) and a per-register pending scoreboard.
module regbank_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int RD_PORTS = 2,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          reset,
  regbank_mp_if.slave   bus
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]          regs [NREGS];
  logic [NREGS-1:0]           sb_q;
  logic [NREGS-1:0]           sb_d;
  logic                       wa_ok;
  logic                       wb_ok;
  logic [RD_PORTS*DATA_W-1:0] rd_data_d;
  logic [RD_PORTS*DATA_W-1:0] rd_data_q;
  logic [RD_PORTS-1:0]        rd_pend_d;
  logic [RD_PORTS-1:0]        rd_pend_q;
  logic                       pend_any_q;

  // Port B is suppressed when A targets the same register so A wins.
  assign wa_ok = bus.wa_we && !((ZERO_REG != 0) && (bus.wa_addr == '0));
  assign wb_ok = bus.wb_we && !((ZERO_REG != 0) && (bus.wb_addr == '0))
                 && !(wa_ok && (bus.wb_addr == bus.wa_addr));

  always_comb begin
    sb_d = sb_q;
    if (wa_ok)        sb_d[bus.wa_addr]   = 1'b0;
    if (wb_ok)        sb_d[bus.wb_addr]   = 1'b0;
    if (bus.pend_set) sb_d[bus.pend_addr] = 1'b1;
    if (ZERO_REG != 0) sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      sb_q <= '0;
    end else begin
      if (wa_ok) regs[bus.wa_addr] <= bus.wa_data;
      if (wb_ok) regs[bus.wb_addr] <= bus.wb_data;
      sb_q <= sb_d;
    end
  end

  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d_next;

    assign addr = bus.rd_addr[i*ADDR_W +: ADDR_W];

    // Same-edge writes bypass the array so the result is already current.
    always_comb begin
      d_next = regs[addr];
      if ((ZERO_REG != 0) && (addr == '0))         d_next = '0;
      else if (bus.wa_we && (bus.wa_addr == addr)) d_next = bus.wa_data;
      else if (bus.wb_we && (bus.wb_addr == addr)) d_next = bus.wb_data;
    end

    assign rd_data_d[i*DATA_W +: DATA_W] = d_next;
    assign rd_pend_d[i]                  = sb_d[addr];
  end

  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      rd_data_q <= '0;
      rd_pend_q <= '0;
    end else if (!bus.hold) begin
      rd_data_q <= rd_data_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pend_any_q <= 1'b0;
    else       pend_any_q <= |sb_d;
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_pending = rd_pend_q;
  assign bus.pend_any   = pend_any_q;
endmodule

// File: tb/tb_regbank_mp.sv
// Bench for regbank_mp: default bank (reg0 hardwired), a ZERO_REG=0 twin in
// lockstep, and a 3-port 16-bit/32-register variant.
module tb_regbank_mp;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  regbank_mp_if bus0 ();
  regbank_mp_if bus1 ();
  regbank_mp_if #(.DATA_W(16), .ADDR_W(5), .RD_PORTS(3)) bus2 ();

  regbank_mp #(.ZERO_REG(1)) u_d0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  regbank_mp #(.ZERO_REG(0)) u_d1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  regbank_mp #(.DATA_W(16), .ADDR_W(5), .RD_PORTS(3), .ZERO_REG(1))
    u_d2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  assign bus1.rd_addr   = bus0.rd_addr;
  assign bus1.hold      = bus0.hold;
  assign bus1.clear     = bus0.clear;
  assign bus1.wa_we     = bus0.wa_we;
  assign bus1.wa_addr   = bus0.wa_addr;
  assign bus1.wa_data   = bus0.wa_data;
  assign bus1.wb_we     = bus0.wb_we;
  assign bus1.wb_addr   = bus0.wb_addr;
  assign bus1.wb_data   = bus0.wb_data;
  assign bus1.pend_set  = bus0.pend_set;
  assign bus1.pend_addr = bus0.pend_addr;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (z=0: reg0 hardwired, z=1: plain) -------
  logic [31:0] m_mem  [32];
  logic [15:0] m_sb   [2];
  logic [31:0] m_rd   [4];
  logic        m_pend [4];
  logic        m_any  [2];

  // Reads return the register contents as they stand after this edge's writes.
  task automatic model_edge();
    for (int z = 0; z < 2; z++) begin
      logic [31:0] nm [16];
      logic [15:0] nsb;
      logic [3:0]  a;
      if (reset) begin
        for (int r = 0; r < 16; r++) m_mem[z*16+r] = '0;
        m_sb[z] = '0;
        for (int p = 0; p < 2; p++) begin m_rd[z*2+p] = '0; m_pend[z*2+p] = 1'b0; end
        m_any[z] = 1'b0;
      end else begin
        for (int r = 0; r < 16; r++) nm[r] = m_mem[z*16+r];
        if (bus0.wb_we) nm[bus0.wb_addr] = bus0.wb_data;
        if (bus0.wa_we) nm[bus0.wa_addr] = bus0.wa_data;
        if (z == 0) nm[0] = '0;
        nsb = m_sb[z];
        if (bus0.wa_we)    nsb[bus0.wa_addr]   = 1'b0;
        if (bus0.wb_we)    nsb[bus0.wb_addr]   = 1'b0;
        if (bus0.pend_set) nsb[bus0.pend_addr] = 1'b1;
        if (z == 0) nsb[0] = 1'b0;
        for (int p = 0; p < 2; p++) begin
          a = bus0.rd_addr[p*4 +: 4];
          if (bus0.clear) begin
            m_rd[z*2+p] = '0; m_pend[z*2+p] = 1'b0;
          end else if (!bus0.hold) begin
            m_rd[z*2+p] = nm[a]; m_pend[z*2+p] = nsb[a];
          end
        end
        for (int r = 0; r < 16; r++) m_mem[z*16+r] = nm[r];
        m_sb[z]  = nsb;
        m_any[z] = |nsb;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus0.rd_addr = '0; bus0.hold = 0; bus0.clear = 0;
    bus0.wa_we = 0; bus0.wa_addr = '0; bus0.wa_data = '0;
    bus0.wb_we = 0; bus0.wb_addr = '0; bus0.wb_data = '0;
    bus0.pend_set = 0; bus0.pend_addr = '0;
    bus2.rd_addr = '0; bus2.hold = 0; bus2.clear = 0;
    bus2.wa_we = 0; bus2.wa_addr = '0; bus2.wa_data = '0;
    bus2.wb_we = 0; bus2.wb_addr = '0; bus2.wb_data = '0;
    bus2.pend_set = 0; bus2.pend_addr = '0;
  endtask

  task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1);
    bus0.rd_addr = {a1, a0};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    reset = 1'b1;
    bus0.wa_we = 1; bus0.wa_addr = 4'd5; bus0.wa_data = 32'h55;
    bus0.pend_set = 1; bus0.pend_addr = 4'd6;
    tick();
    reset = 1'b0;
    idle();
    checks++;
    if (bus0.rd_data !== '0 || bus0.rd_pending !== '0 || bus0.pend_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got %h/%b/%b exp 0/0/0", bus0.rd_data, bus0.rd_pending, bus0.pend_any);
    end
    for (int r = 1; r < 16; r++) begin
      set_rd(4'(r), 4'(r));
      tick();
      checks++;
      if (bus0.rd_data !== '0 || bus1.rd_data !== '0 || bus0.rd_pending !== '0
          || bus1.rd_pending !== '0 || bus0.pend_any !== 1'b0 || bus1.pend_any !== 1'b0) begin
        errors++;
        $display("FAIL reset_read r%0d got %h/%h pend %b/%b exp all zero",
                 r, bus0.rd_data, bus1.rd_data, bus0.rd_pending, bus1.pend_any);
      end
    end
    idle();
    bus0.wa_we = 1; bus0.wa_addr = 4'd3; bus0.wa_data = 32'hDEADBEEF;
    tick();
    idle();
    set_rd(4'd3, 4'd0);
    tick();
    checks++;
    if (bus0.rd_data[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_r3 got %h exp deadbeef", bus0.rd_data[31:0]);
    end
  endtask

  task automatic test_write_ports();
    idle();
    bus0.wa_we = 1; bus0.wa_addr = 4'd5; bus0.wa_data = 32'h11;
    bus0.wb_we = 1; bus0.wb_addr = 4'd5; bus0.wb_data = 32'h22;
    set_rd(4'd5, 4'd0);
    tick();
    checks++;
    if (bus0.rd_data[31:0] !== 32'h11) begin
      errors++;
      $display("FAIL collide_bypass got %h exp 11", bus0.rd_data[31:0]);
    end
    idle();
    set_rd(4'd1, 4'd5);
    tick();
    checks++;
    if (bus0.rd_data[63:32] !== 32'h11) begin
      errors++;
      $display("FAIL collide_stored got %h exp 11", bus0.rd_data[63:32]);
    end
    bus0.wa_we = 1; bus0.wa_addr = 4'd6; bus0.wa_data = 32'h33;
    bus0.wb_we = 1; bus0.wb_addr = 4'd7; bus0.wb_data = 32'h44;
    set_rd(4'd0, 4'd0);
    tick();
    idle();
    set_rd(4'd6, 4'd7);
    tick();
    checks++;
    if (bus0.rd_data !== {32'h44, 32'h33}) begin
      errors++;
      $display("FAIL dual_write got %h exp 00000044_00000033", bus0.rd_data);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    bus0.wa_we = 1; bus0.wa_addr = 4'd0; bus0.wa_data = 32'hFFFF;
    tick();
    idle();
    set_rd(4'd0, 4'd0);
    tick();
    checks++;
    if (bus0.rd_data[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL zero_reg_on got %h exp 0", bus0.rd_data[31:0]);
    end
    checks++;
    if (bus1.rd_data[31:0] !== 32'hFFFF) begin
      errors++;
      $display("FAIL zero_reg_off got %h exp ffff", bus1.rd_data[31:0]);
    end
    bus0.pend_set = 1; bus0.pend_addr = 4'd0;
    tick();
    idle();
    checks++;
    if (bus0.rd_pending[0] !== 1'b0 || bus0.pend_any !== 1'b0) begin
      errors++;
      $display("FAIL zero_reg_pend_on got %b/%b exp 0/0", bus0.rd_pending[0], bus0.pend_any);
    end
    checks++;
    if (bus1.rd_pending[0] !== 1'b1 || bus1.pend_any !== 1'b1) begin
      errors++;
      $display("FAIL zero_reg_pend_off got %b/%b exp 1/1", bus1.rd_pending[0], bus1.pend_any);
    end
    bus0.wa_we = 1; bus0.wa_addr = 4'd0; bus0.wa_data = 32'h0;
    tick();
    idle();
    checks++;
    if (bus1.pend_any !== 1'b0) begin
      errors++;
      $display("FAIL zero_reg_pend_clr got %b exp 0", bus1.pend_any);
    end
  endtask

  task automatic test_hold_clear();
    idle();
    bus0.wa_we = 1; bus0.wa_addr = 4'd2; bus0.wa_data = 32'hAA;
    tick();
    idle();
    set_rd(4'd2, 4'd0);
    tick();
    checks++;
    if (bus0.rd_data[31:0] !== 32'hAA) begin
      errors++;
      $display("FAIL hold_load got %h exp aa", bus0.rd_data[31:0]);
    end
    bus0.hold = 1;
    bus0.wa_we = 1; bus0.wa_addr = 4'd2; bus0.wa_data = 32'hBB;
    tick();
    bus0.wa_we = 0;
    checks++;
    if (bus0.rd_data[31:0] !== 32'hAA) begin
      errors++;
      $display("FAIL hold_keep got %h exp aa", bus0.rd_data[31:0]);
    end
    bus0.pend_set = 1; bus0.pend_addr = 4'd4;
    tick();
    bus0.pend_set = 0;
    checks++;
    if (bus0.rd_data[31:0] !== 32'hAA || bus0.pend_any !== 1'b1) begin
      errors++;
      $display("FAIL hold_pend_any got %h/%b exp aa/1", bus0.rd_data[31:0], bus0.pend_any);
    end
    bus0.hold = 0;
    bus0.wa_we = 1; bus0.wa_addr = 4'd4; bus0.wa_data = 32'h4;
    tick();
    bus0.wa_we = 0;
    checks++;
    if (bus0.rd_data[31:0] !== 32'hBB || bus0.pend_any !== 1'b0) begin
      errors++;
      $display("FAIL hold_release got %h/%b exp bb/0", bus0.rd_data[31:0], bus0.pend_any);
    end
    bus0.clear = 1;
    tick();
    bus0.clear = 0;
    checks++;
    if (bus0.rd_data !== '0 || bus0.rd_pending !== '0) begin
      errors++;
      $display("FAIL clear_out got %h/%b exp 0/0", bus0.rd_data, bus0.rd_pending);
    end
    tick();
    checks++;
    if (bus0.rd_data[31:0] !== 32'hBB) begin
      errors++;
      $display("FAIL clear_keeps_array got %h exp bb", bus0.rd_data[31:0]);
    end
  endtask

  task automatic test_pending();
    idle();
    set_rd(4'd9, 4'd9);
    bus0.pend_set = 1; bus0.pend_addr = 4'd9;
    tick();
    idle();
    set_rd(4'd9, 4'd9);
    checks++;
    if (bus0.rd_pending !== 2'b11 || bus0.pend_any !== 1'b1) begin
      errors++;
      $display("FAIL pend_set got %b/%b exp 11/1", bus0.rd_pending, bus0.pend_any);
    end
    bus0.wb_we = 1; bus0.wb_addr = 4'd9; bus0.wb_data = 32'h99;
    bus0.pend_set = 1; bus0.pend_addr = 4'd9;
    tick();
    idle();
    set_rd(4'd9, 4'd9);
    checks++;
    if (bus0.rd_pending[0] !== 1'b1 || bus0.pend_any !== 1'b1 || bus0.rd_data[31:0] !== 32'h99) begin
      errors++;
      $display("FAIL pend_set_wins got %b/%b/%h exp 1/1/99",
               bus0.rd_pending[0], bus0.pend_any, bus0.rd_data[31:0]);
    end
    bus0.wa_we = 1; bus0.wa_addr = 4'd9; bus0.wa_data = 32'h9A;
    tick();
    idle();
    checks++;
    if (bus0.rd_pending[0] !== 1'b0 || bus0.pend_any !== 1'b0) begin
      errors++;
      $display("FAIL pend_clear got %b/%b exp 0/0", bus0.rd_pending[0], bus0.pend_any);
    end
  endtask

  task automatic test_wide_ports();
    idle();
    reset = 1'b1;
    bus2.wa_we = 1; bus2.wa_addr = 5'd31; bus2.wa_data = 16'h1234;
    tick();
    reset = 1'b0;
    idle();
    bus2.rd_addr = {5'd31, 5'd0, 5'd31};
    tick();
    checks++;
    if (bus2.rd_data !== 48'h0) begin
      errors++;
      $display("FAIL wide_reset_wins got %h exp 0", bus2.rd_data);
    end
    bus2.wa_we = 1; bus2.wa_addr = 5'd31; bus2.wa_data = 16'h1234;
    bus2.rd_addr = {5'd1, 5'd1, 5'd1};
    tick();
    bus2.wa_we = 0;
    bus2.rd_addr = {5'd31, 5'd0, 5'd31};
    tick();
    checks++;
    if (bus2.rd_data !== {16'h1234, 16'h0, 16'h1234}) begin
      errors++;
      $display("FAIL wide_three_ports got %h exp 1234_0000_1234", bus2.rd_data);
    end
  endtask

  task automatic test_random();
    idle();
    for (int n = 0; n < 400; n++) begin
      bus0.wa_we     = ($urandom_range(0, 1) == 1);
      bus0.wa_addr   = 4'($urandom_range(0, 15));
      bus0.wa_data   = $urandom;
      bus0.wb_we     = ($urandom_range(0, 1) == 1);
      bus0.wb_addr   = ($urandom_range(0, 3) == 0) ? bus0.wa_addr : 4'($urandom_range(0, 15));
      bus0.wb_data   = $urandom;
      bus0.pend_set  = ($urandom_range(0, 2) == 0);
      bus0.pend_addr = ($urandom_range(0, 3) == 0) ? bus0.wa_addr : 4'($urandom_range(0, 15));
      bus0.hold      = ($urandom_range(0, 7) == 0);
      bus0.clear     = ($urandom_range(0, 15) == 0);
      bus0.rd_addr   = ($urandom_range(0, 2) == 0) ? {bus0.wb_addr, bus0.wa_addr}
                                                   : 8'($urandom_range(0, 255));
      tick();
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (bus0.rd_data[p*32 +: 32] !== m_rd[p] || bus0.rd_pending[p] !== m_pend[p]) begin
          errors++;
          $display("FAIL rand_z1 n%0d p%0d got %h/%b exp %h/%b",
                   n, p, bus0.rd_data[p*32 +: 32], bus0.rd_pending[p], m_rd[p], m_pend[p]);
        end
        checks++;
        if (bus1.rd_data[p*32 +: 32] !== m_rd[2+p] || bus1.rd_pending[p] !== m_pend[2+p]) begin
          errors++;
          $display("FAIL rand_z0 n%0d p%0d got %h/%b exp %h/%b",
                   n, p, bus1.rd_data[p*32 +: 32], bus1.rd_pending[p], m_rd[2+p], m_pend[2+p]);
        end
      end
      checks++;
      if (bus0.pend_any !== m_any[0] || bus1.pend_any !== m_any[1]) begin
        errors++;
        $display("FAIL rand_pend_any n%0d got %b/%b exp %b/%b",
                 n, bus0.pend_any, bus1.pend_any, m_any[0], m_any[1]);
      end
    end
    idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_write_ports();
    test_zero_reg();
    test_hold_clear();
    test_pending();
    test_wide_ports();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
